bank_cmd_issuer: RTL and testbench
==================================

// Module: bank_cmd_issuer
// PURPOSE
//  Sits directly downstream of the 16-bank Arbiter: buffers each granted request (pushed by wr_en) in a FIFO, tracks the open row of all 16 banks (index = {bg,ba}),
//  and turns each request into a timed DRAM command sequence (PRE/ACT/RD/WR) toward the PHY over a valid/ready handshake. Asserts full back to the Arbiter.
// PARAMETERS
//  INDEX_BITS  7   request index width
//  RA_BITS     16  row address width
//  CA_BITS     10  column address width
//  DATA_BITS   16  write data width
//  FIFO_DEPTH  8   request FIFO entries (power of 2)
//  T_RP        3   cycles from PRE issue to earliest ACT (>=1)
//  T_RCD       3   cycles from ACT issue to earliest RD/WR (>=1)
//  T_CCD       2   cycles from RD/WR issue to earliest next command (>=1)
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          asynchronous, active-high reset
//  wr_en      in   1          push Arbiter output into FIFO
//  type_i     in   1          0 = read, 1 = write
//  data_i     in   DATA_BITS  write data
//  idx_i      in   INDEX_BITS request index
//  row_i      in   RA_BITS    row address
//  col_i      in   CA_BITS    column address
//  ba_i       in   2          bank address
//  bg_i       in   2          bank group
//  full       out  1          FIFO full (registered count == FIFO_DEPTH)
//  overflow   out  1          sticky: wr_en seen while full
//  phy_ready  in   1          PHY accepts cmd this cycle
//  cmd_valid  out  1          cmd_* fields valid
//  cmd        out  3          000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE
//  cmd_ba/cmd_bg out 2 each   target bank / group
//  cmd_row    out  RA_BITS    row (ACT only, else 0)
//  cmd_col    out  CA_BITS    column (RD/WR only, else 0)
//  cmd_data   out  DATA_BITS  write data (WR only, else 0)
//  cmd_idx    out  INDEX_BITS request index (RD/WR only, else 0)
// BEHAVIOUR
//  Reset: every output 0 (cmd=NOP, full=0, overflow=0), FIFO empty, all 16 open-row entries invalid, timers 0, FSM=IDLE. Reset mid-sequence aborts; nothing replays.
//  FIFO: push iff wr_en && !full; wr_en && full drops request and sets overflow until reset. Push+pop same cycle while full: push still rejected (full registered).
//   Pop only on the RD/WR handshake (cmd_valid && phy_ready). Pointers wrap mod FIFO_DEPTH.
//  Handshake: a command counts as issued only in a cycle with cmd_valid && phy_ready; while phy_ready=0 all cmd_* held stable, FSM and timers frozen.
//  FSM: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RDWR, WAIT_CCD.
//   IDLE: FIFO empty -> stay. Else look up head bank {bg,ba}:
//    open & row match (hit) -> RDWR; invalid (closed) -> ACT; open & row differs (conflict) -> PRE.
//   PRE: cmd=PRE; on issue clear entry valid, load timer T_RP-1 -> WAIT_RP (timer 0 -> ACT directly).
//   WAIT_RP: cmd_valid=0, decrement; at 0 -> ACT.
//   ACT: cmd=ACT, cmd_row=head row; on issue set entry {valid=1,row}, load T_RCD-1 -> WAIT_RCD (0 -> RDWR).
//   WAIT_RCD: decrement; at 0 -> RDWR.
//   RDWR: cmd=RD/WR per type, col/idx/data from head; on issue pop, load T_CCD-1 -> WAIT_CCD (0 -> IDLE).
//   WAIT_CCD: decrement; at 0 -> IDLE.
//  Latency (push in cycle N, phy_ready=1): hit -> RD/WR in N+2; closed -> ACT N+2, RD/WR N+2+T_RCD;
//   conflict -> PRE N+2, ACT N+2+T_RP, RD/WR N+2+T_RP+T_RCD.
//  Rows stay open after RD/WR (open-page policy); no auto-precharge, no refresh.
//  Head entry is never modified while being served; new pushes during a sequence only queue.
// TESTING
//  1 Reset: assert rst mid-ACT with 3 entries queued -> all outputs 0 next cycle, full=0, later same-row request needs ACT again (table cleared).
//  2 Closed bank: push RD bg=1 ba=2 row=0x0A5 col=0x010 at N -> ACT row 0x0A5 at N+2, RD col 0x010 at N+5.
//  3 Hit: follow with WR same bank row 0x0A5 col=0x011 data=0xBEEF -> WR at IDLE+1, no ACT/PRE; cmd_data=0xBEEF.
//  4 Conflict: RD same bank row 0x0A6 -> PRE, ACT 0x0A6 exactly T_RP later, RD T_RCD after ACT.
//  5 Backpressure: hold phy_ready=0 4 cycles during ACT -> cmd/cmd_row stable, ACT issued on first ready cycle, RD T_RCD after.
//  6 Full: push 9 requests back-to-back, phy_ready=0 -> full after 8th, 9th dropped, overflow=1 sticky; release -> exactly 8 RD/WR in FIFO order (idx check).

Source files
------------

// File: rtl/bank_cmd_issuer.sv
// bank_cmd_issuer: queues granted requests from the bank arbiter, tracks the
// open row of all 16 banks and turns each request into a timed
// PRE/ACT/RD/WR sequence toward the PHY over a valid/ready handshake.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for a queued request; classifies head as hit/closed/conflict
// S_PRE      | presenting PRE for the head bank
// S_WAIT_RP  | precharge recovery countdown before ACT
// S_ACT      | presenting ACT with the head row
// S_WAIT_RCD | activate-to-column countdown before RD/WR
// S_RDWR     | presenting RD or WR for the head request; pops on issue
// S_WAIT_CCD | column-to-next-command countdown
module bank_cmd_issuer #(
  parameter int INDEX_BITS = 7,
  parameter int RA_BITS    = 16,
  parameter int CA_BITS    = 10,
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int T_RP       = 3,
  parameter int T_RCD      = 3,
  parameter int T_CCD      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  type_i,
  input  logic [DATA_BITS-1:0]  data_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [RA_BITS-1:0]    row_i,
  input  logic [CA_BITS-1:0]    col_i,
  input  logic [1:0]            ba_i,
  input  logic [1:0]            bg_i,
  output logic                  full,
  output logic                  overflow,
  input  logic                  phy_ready,
  output logic                  cmd_valid,
  output logic [2:0]            cmd,
  output logic [1:0]            cmd_ba,
  output logic [1:0]            cmd_bg,
  output logic [RA_BITS-1:0]    cmd_row,
  output logic [CA_BITS-1:0]    cmd_col,
  output logic [DATA_BITS-1:0]  cmd_data,
  output logic [INDEX_BITS-1:0] cmd_idx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 8;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ACT = 3'b001;
  localparam logic [2:0] OP_RD  = 3'b010;
  localparam logic [2:0] OP_WR  = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RDWR, S_WAIT_CCD
  } state_t;

  typedef struct packed {
    logic                  typ;
    logic [DATA_BITS-1:0]  data;
    logic [INDEX_BITS-1:0] idx;
    logic [RA_BITS-1:0]    row;
    logic [CA_BITS-1:0]    col;
    logic [1:0]            ba;
    logic [1:0]            bg;
  } req_t;

  typedef struct packed {
    logic                  valid;
    logic [2:0]            op;
    logic [1:0]            ba;
    logic [1:0]            bg;
    logic [RA_BITS-1:0]    row;
    logic [CA_BITS-1:0]    col;
    logic [DATA_BITS-1:0]  data;
    logic [INDEX_BITS-1:0] idx;
  } cmd_t;

  req_t               fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  req_t               head;
  logic               push;
  logic               pop;

  state_t             state;
  logic [TW-1:0]      timer;
  cmd_t               out_q;
  logic [15:0]        open_valid;
  logic [RA_BITS-1:0] open_row [16];
  logic [3:0]         bank;
  logic               head_open;
  logic               hit;
  cmd_t               pre_cmd;
  cmd_t               act_cmd;
  cmd_t               rw_cmd;

  assign head      = fifo_mem[rd_ptr];
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push      = wr_en && !full;
  assign pop       = (state == S_RDWR) && out_q.valid && phy_ready;
  assign bank      = {head.bg, head.ba};
  assign head_open = open_valid[bank];
  assign hit       = head_open && (open_row[bank] == head.row);

  // FIFO bookkeeping and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // FIFO storage; only the tail slot is written, so the head being served is untouched
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{typ: type_i, data: data_i, idx: idx_i, row: row_i,
                            col: col_i, ba: ba_i, bg: bg_i};
    end
  end

  // Command images for the head request; unused fields stay zero
  always_comb begin
    pre_cmd       = '0;
    pre_cmd.valid = 1'b1;
    pre_cmd.op    = OP_PRE;
    pre_cmd.ba    = head.ba;
    pre_cmd.bg    = head.bg;

    act_cmd       = '0;
    act_cmd.valid = 1'b1;
    act_cmd.op    = OP_ACT;
    act_cmd.ba    = head.ba;
    act_cmd.bg    = head.bg;
    act_cmd.row   = head.row;

    rw_cmd        = '0;
    rw_cmd.valid  = 1'b1;
    rw_cmd.op     = head.typ ? OP_WR : OP_RD;
    rw_cmd.ba     = head.ba;
    rw_cmd.bg     = head.bg;
    rw_cmd.col    = head.col;
    rw_cmd.data   = head.typ ? head.data : '0;
    rw_cmd.idx    = head.idx;
  end

  // Sequencer, open-row table and registered command outputs; everything holds while the PHY stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      out_q      <= '0;
      open_valid <= '0;
      for (int i = 0; i < 16; i++) open_row[i] <= '0;
    end else if (phy_ready) begin
      unique case (state)
        S_IDLE: begin
          if (count != '0) begin
            if (hit) begin
              state <= S_RDWR;
              out_q <= rw_cmd;
            end else if (head_open) begin
              state <= S_PRE;
              out_q <= pre_cmd;
            end else begin
              state <= S_ACT;
              out_q <= act_cmd;
            end
          end
        end
        S_PRE: begin
          open_valid[bank] <= 1'b0;
          if (T_RP > 1) begin
            state <= S_WAIT_RP;
            timer <= TW'(T_RP - 1);
            out_q <= '0;
          end else begin
            state <= S_ACT;
            out_q <= act_cmd;
          end
        end
        S_WAIT_RP: begin
          timer <= timer - TW'(1);
          if (timer == TW'(1)) begin
            state <= S_ACT;
            out_q <= act_cmd;
          end
        end
        S_ACT: begin
          open_valid[bank] <= 1'b1;
          open_row[bank]   <= head.row;
          if (T_RCD > 1) begin
            state <= S_WAIT_RCD;
            timer <= TW'(T_RCD - 1);
            out_q <= '0;
          end else begin
            state <= S_RDWR;
            out_q <= rw_cmd;
          end
        end
        S_WAIT_RCD: begin
          timer <= timer - TW'(1);
          if (timer == TW'(1)) begin
            state <= S_RDWR;
            out_q <= rw_cmd;
          end
        end
        S_RDWR: begin
          out_q <= '0;
          if (T_CCD > 1) begin
            state <= S_WAIT_CCD;
            timer <= TW'(T_CCD - 1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT_CCD: begin
          timer <= timer - TW'(1);
          if (timer == TW'(1)) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          out_q <= '0;
        end
      endcase
    end
  end

  assign cmd_valid = out_q.valid;
  assign cmd       = out_q.valid ? out_q.op : OP_NOP;
  assign cmd_ba    = out_q.ba;
  assign cmd_bg    = out_q.bg;
  assign cmd_row   = out_q.row;
  assign cmd_col   = out_q.col;
  assign cmd_data  = out_q.data;
  assign cmd_idx   = out_q.idx;

endmodule

// File: tb/tb_bank_cmd_issuer.sv
// Directed bench for bank_cmd_issuer: a cycle table for closed/hit/conflict
// and backpressure, plus hand-written reset-abort and FIFO-full sequences.
module tb_bank_cmd_issuer;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ACT = 3'b001;
  localparam logic [2:0] OP_RD  = 3'b010;
  localparam logic [2:0] OP_WR  = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam int         NVEC   = 28;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, type_i, phy_ready;
  logic [15:0] data_i, row_i;
  logic [6:0]  idx_i;
  logic [9:0]  col_i;
  logic [1:0]  ba_i, bg_i;
  logic        full, overflow, cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cmd_ba, cmd_bg;
  logic [15:0] cmd_row, cmd_data;
  logic [9:0]  cmd_col;
  logic [6:0]  cmd_idx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic        typ;
    logic [15:0] row;
    logic [9:0]  col;
    logic [15:0] data;
    logic [6:0]  idx;
    logic [1:0]  ba;
    logic [1:0]  bg;
    logic        rdy;
  } in_t;

  typedef struct packed {
    logic        v;
    logic [2:0]  op;
    logic [15:0] row;
    logic [9:0]  col;
    logic [15:0] data;
    logic [6:0]  idx;
    logic [1:0]  ba;
    logic [1:0]  bg;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vecs [NVEC];

  bank_cmd_issuer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .type_i(type_i), .data_i(data_i),
    .idx_i(idx_i), .row_i(row_i), .col_i(col_i), .ba_i(ba_i), .bg_i(bg_i),
    .full(full), .overflow(overflow), .phy_ready(phy_ready),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba), .cmd_bg(cmd_bg),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data), .cmd_idx(cmd_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic in_t pin(input logic typ, input logic [15:0] row, input logic [9:0] col,
                              input logic [15:0] data, input logic [6:0] idx,
                              input logic [1:0] ba, input logic [1:0] bg);
    in_t x;
    x = '{we: 1'b1, typ: typ, row: row, col: col, data: data, idx: idx, ba: ba, bg: bg, rdy: 1'b1};
    return x;
  endfunction

  function automatic exp_t ecmd(input logic [2:0] op, input logic [15:0] row, input logic [9:0] col,
                                input logic [15:0] data, input logic [6:0] idx,
                                input logic [1:0] ba, input logic [1:0] bg);
    exp_t x;
    x = '{v: 1'b1, op: op, row: row, col: col, data: data, idx: idx, ba: ba, bg: bg};
    return x;
  endfunction

  task automatic drive(input in_t x);
    wr_en     = x.we;
    type_i    = x.typ;
    row_i     = x.row;
    col_i     = x.col;
    data_i    = x.data;
    idx_i     = x.idx;
    ba_i      = x.ba;
    bg_i      = x.bg;
    phy_ready = x.rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cmd(input string tag, input exp_t e);
    check({tag, ".valid"}, 32'(cmd_valid), 32'(e.v));
    check({tag, ".cmd"},   32'(cmd),       32'(e.op));
    if (e.v) begin
      check({tag, ".row"},  32'(cmd_row),  32'(e.row));
      check({tag, ".col"},  32'(cmd_col),  32'(e.col));
      check({tag, ".data"}, 32'(cmd_data), 32'(e.data));
      check({tag, ".idx"},  32'(cmd_idx),  32'(e.idx));
      check({tag, ".ba"},   32'(cmd_ba),   32'(e.ba));
      check({tag, ".bg"},   32'(cmd_bg),   32'(e.bg));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  idle_in;
    exp_t act123;
    exp_t nop;
    int   got;

    idle_in     = '0;
    idle_in.rdy = 1'b1;
    nop         = '0;

    // Cycle table: row r inputs are applied for one cycle, outputs checked after that edge
    for (int r = 0; r < NVEC; r++) begin
      vecs[r].i = idle_in;
      vecs[r].e = nop;
    end
    // closed bank bg=1 ba=2: ACT at N+2, RD at N+5
    vecs[0].i  = pin(1'b0, 16'h00A5, 10'h010, 16'h0000, 7'd1, 2'd2, 2'd1);
    vecs[1].e  = ecmd(OP_ACT, 16'h00A5, 10'h000, 16'h0000, 7'd0, 2'd2, 2'd1);
    vecs[4].e  = ecmd(OP_RD,  16'h0000, 10'h010, 16'h0000, 7'd1, 2'd2, 2'd1);
    // row hit: WR one cycle after IDLE, no ACT/PRE
    vecs[5].i  = pin(1'b1, 16'h00A5, 10'h011, 16'hBEEF, 7'd2, 2'd2, 2'd1);
    vecs[7].e  = ecmd(OP_WR,  16'h0000, 10'h011, 16'hBEEF, 7'd2, 2'd2, 2'd1);
    // row conflict: PRE, ACT T_RP later, RD T_RCD after ACT
    vecs[8].i  = pin(1'b0, 16'h00A6, 10'h020, 16'h0000, 7'd3, 2'd2, 2'd1);
    vecs[10].e = ecmd(OP_PRE, 16'h0000, 10'h000, 16'h0000, 7'd0, 2'd2, 2'd1);
    vecs[13].e = ecmd(OP_ACT, 16'h00A6, 10'h000, 16'h0000, 7'd0, 2'd2, 2'd1);
    vecs[16].e = ecmd(OP_RD,  16'h0000, 10'h020, 16'h0000, 7'd3, 2'd2, 2'd1);
    // backpressure on ACT for 4 cycles, then RD T_RCD after the real issue
    act123     = ecmd(OP_ACT, 16'h0123, 10'h000, 16'h0000, 7'd0, 2'd1, 2'd0);
    vecs[17].i = pin(1'b0, 16'h0123, 10'h030, 16'h0000, 7'd4, 2'd1, 2'd0);
    vecs[19].e = act123;
    for (int r = 20; r < 24; r++) begin
      vecs[r].i.rdy = 1'b0;
      vecs[r].e     = act123;
    end
    vecs[26].e = ecmd(OP_RD,  16'h0000, 10'h030, 16'h0000, 7'd4, 2'd1, 2'd0);

    // Reset state
    drive(idle_in);
    rst = 1'b1;
    tick();
    tick();
    check("reset.valid", 32'(cmd_valid), 32'd0);
    check("reset.cmd", 32'(cmd), 32'(OP_NOP));
    check("reset.full", 32'(full), 32'd0);
    check("reset.overflow", 32'(overflow), 32'd0);
    check("reset.row", 32'(cmd_row), 32'd0);
    rst = 1'b0;

    for (int r = 0; r < NVEC; r++) begin
      drive(vecs[r].i);
      tick();
      check_cmd($sformatf("vec%0d", r), vecs[r].e);
      check($sformatf("vec%0d.full", r), 32'(full), 32'd0);
    end
    drive(idle_in);
    tick();

    // Reset mid-ACT with 3 requests queued
    drive(pin(1'b0, 16'h0055, 10'h001, 16'h0000, 7'd10, 2'd3, 2'd2));
    tick();
    drive(pin(1'b0, 16'h0055, 10'h002, 16'h0000, 7'd11, 2'd3, 2'd2));
    tick();
    check_cmd("rst_seq.act", ecmd(OP_ACT, 16'h0055, 10'h000, 16'h0000, 7'd0, 2'd3, 2'd2));
    drive(pin(1'b0, 16'h0055, 10'h003, 16'h0000, 7'd12, 2'd3, 2'd2));
    phy_ready = 1'b0;
    tick();
    check_cmd("rst_seq.held", ecmd(OP_ACT, 16'h0055, 10'h000, 16'h0000, 7'd0, 2'd3, 2'd2));
    drive(idle_in);
    phy_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_seq.valid", 32'(cmd_valid), 32'd0);
    check("rst_seq.cmd", 32'(cmd), 32'(OP_NOP));
    check("rst_seq.row", 32'(cmd_row), 32'd0);
    check("rst_seq.full", 32'(full), 32'd0);
    rst = 1'b0;
    // bank bg=0 ba=1 had row 0x123 open before reset; it must need ACT again
    drive(pin(1'b0, 16'h0123, 10'h040, 16'h0000, 7'd13, 2'd1, 2'd0));
    tick();
    drive(idle_in);
    check_cmd("rst_seq.n1", nop);
    tick();
    check_cmd("rst_seq.reopen", act123);
    tick();
    check_cmd("rst_seq.n3", nop);
    tick();
    check_cmd("rst_seq.n4", nop);
    tick();
    check_cmd("rst_seq.rd", ecmd(OP_RD, 16'h0000, 10'h040, 16'h0000, 7'd13, 2'd1, 2'd0));
    repeat (4) tick();

    // FIFO full: 9 pushes with the PHY stalled
    for (int i = 0; i < 9; i++) begin
      drive(pin(1'(i % 2), 16'h0200, 10'(10'h100 + i), 16'(16'h1000 + i), 7'(20 + i), 2'd0, 2'd3));
      phy_ready = 1'b0;
      tick();
      if (i == 6) check("fill.full_at7", 32'(full), 32'd0);
      if (i == 7) begin
        check("fill.full_at8", 32'(full), 32'd1);
        check("fill.ovf_at8", 32'(overflow), 32'd0);
      end
      if (i == 8) begin
        check("fill.full_at9", 32'(full), 32'd1);
        check("fill.ovf_at9", 32'(overflow), 32'd1);
      end
    end
    drive(idle_in);
    phy_ready = 1'b0;
    repeat (3) tick();
    check("fill.ovf_sticky", 32'(overflow), 32'd1);
    check("fill.stall_valid", 32'(cmd_valid), 32'd0);
    phy_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 9; c++) begin
      tick();
      if (cmd_valid && (cmd == OP_RD || cmd == OP_WR)) begin
        if (got < 8) begin
          check($sformatf("drain%0d.idx", got), 32'(cmd_idx), 32'(20 + got));
          check($sformatf("drain%0d.cmd", got), 32'(cmd), 32'((got % 2) ? OP_WR : OP_RD));
          check($sformatf("drain%0d.data", got), 32'(cmd_data),
                (got % 2) ? 32'(16'h1000 + got) : 32'd0);
          check($sformatf("drain%0d.col", got), 32'(cmd_col), 32'(10'h100 + got));
        end
        got++;
      end
    end
    check("drain.count", 32'(got), 32'd8);
    check("drain.full", 32'(full), 32'd0);
    check("drain.ovf_sticky", 32'(overflow), 32'd1);

    rst = 1'b1;
    tick();
    check("final_rst.ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
